// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the control unit and the
// sequential ALU. The control unit holds the master side; alu_seq holds the slave side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       opCode;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] resultHigh;
    logic             busy;
    logic             done;
    logic             zeroFlag;
    logic             carryFlag;
    logic             overflowFlag;

    modport master (
        output start, opCode, operand1, operand2,
        input  result, resultHigh, busy, done, zeroFlag, carryFlag, overflowFlag
    );

    modport slave (
        input  start, opCode, operand1, operand2,
        output result, resultHigh, busy, done, zeroFlag, carryFlag, overflowFlag
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential WIDTH-bit ALU: single-cycle logic/arith ops plus a WIDTH-step shift-add MUL.
// Optional macro ALU_SATURATE_EN makes ADD/SUB saturate instead of wrap.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clock,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL1 = 3'd5,
        OP_SHR1 = 3'd6,
        OP_MUL  = 3'd7
    } op_e;

    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e             state, state_next;
    op_e                op;
    logic               accept;
    logic               last_step;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] prod_next;

    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry, alu_ovf;

    logic [WIDTH-1:0]   result_q, high_q;
    logic               done_q, zero_q, carry_q, ovf_q;

    assign op        = op_e'(bus.opCode);
    assign accept    = (state == S_IDLE) && bus.start;
    assign last_step = (cnt == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && op == OP_MUL) state_next = S_MUL;
            S_MUL:   if (last_step) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == S_MUL);
    end

    // Single-cycle datapath, evaluated at WIDTH+1 bits so carry/borrow fall out of the top bit.
    always_comb begin
        sum       = {1'b0, bus.operand1} + {1'b0, bus.operand2};
        diff      = {1'b0, bus.operand1} - {1'b0, bus.operand2};
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.operand1[WIDTH-1]);
`ifdef ALU_SATURATE_EN
                if (sum[WIDTH]) alu_res = '1;
`endif
            end
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.operand1[WIDTH-1]);
`ifdef ALU_SATURATE_EN
                if (diff[WIDTH]) alu_res = '0;
`endif
            end
            OP_AND:  alu_res = bus.operand1 & bus.operand2;
            OP_OR:   alu_res = bus.operand1 | bus.operand2;
            OP_XOR:  alu_res = bus.operand1 ^ bus.operand2;
            OP_SHL1: begin
                alu_res   = {bus.operand1[WIDTH-2:0], 1'b0};
                alu_carry = bus.operand1[WIDTH-1];
            end
            OP_SHR1: begin
                alu_res   = {1'b0, bus.operand1[WIDTH-1:1]};
                alu_carry = bus.operand1[0];
            end
            default: ;
        endcase
    end

    // Multiplier LSB-first: add the multiplicand into the high half, then shift the pair right.
    always_comb begin
        mul_add   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {mul_add, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            result_q <= '0;
            high_q   <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            mcand    <= '0;
            prod     <= '0;
            cnt      <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (op == OP_MUL) begin
                    mcand <= bus.operand1;
                    prod  <= {{WIDTH{1'b0}}, bus.operand2};
                    cnt   <= CNT_W'(WIDTH);
                end else begin
                    result_q <= alu_res;
                    high_q   <= '0;
                    zero_q   <= (alu_res == '0);
                    carry_q  <= alu_carry;
                    ovf_q    <= alu_ovf;
                    done_q   <= 1'b1;
                end
            end else if (state == S_MUL) begin
                prod <= prod_next;
                cnt  <= cnt - CNT_W'(1);
                if (last_step) begin
                    result_q <= prod_next[WIDTH-1:0];
                    high_q   <= prod_next[2*WIDTH-1:WIDTH];
                    zero_q   <= (prod_next == '0);
                    carry_q  <= (prod_next[2*WIDTH-1:WIDTH] != '0);
                    ovf_q    <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.result       = result_q;
    assign bus.resultHigh   = high_q;
    assign bus.done         = done_q;
    assign bus.zeroFlag     = zero_q;
    assign bus.carryFlag    = carry_q;
    assign bus.overflowFlag = ovf_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model compared every cycle,
// plus directed cases with hand-computed expectations. Honours ALU_SATURATE_EN.
module tb_alu_seq;
    localparam int W = 8;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                           OP_XOR = 3'd4, OP_SHL1 = 3'd5, OP_SHR1 = 3'd6, OP_MUL = 3'd7;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
    } out_t;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   cmp_en  = 1'b0;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint to_signed(input longint unsigned x);
        return (x >= (64'd1 << (W - 1))) ? longint'(x) - (longint'(1) << W) : longint'(x);
    endfunction

    // Reference: plain integer arithmetic on the operation's mathematical definition.
    function automatic out_t model(input logic [2:0] op, input longint unsigned a, input longint unsigned b);
        longint unsigned mask = (64'd1 << W) - 1;
        longint          smax = (longint'(1) << (W - 1)) - 1;
        longint          smin = -(longint'(1) << (W - 1));
        longint unsigned raw  = 0;
        longint unsigned hi   = 0;
        longint          sr;
        out_t            o    = '0;
        case (op)
            OP_ADD: begin
                raw = a + b;
                o.c = raw > mask;
                sr  = to_signed(a) + to_signed(b);
                o.v = (sr > smax) || (sr < smin);
                raw = raw & mask;
`ifdef ALU_SATURATE_EN
                if (o.c) raw = mask;
`endif
            end
            OP_SUB: begin
                o.c = a < b;
                raw = (a - b) & mask;
                sr  = to_signed(a) - to_signed(b);
                o.v = (sr > smax) || (sr < smin);
`ifdef ALU_SATURATE_EN
                if (o.c) raw = 0;
`endif
            end
            OP_AND:  raw = a & b;
            OP_OR:   raw = a | b;
            OP_XOR:  raw = a ^ b;
            OP_SHL1: begin raw = (a << 1) & mask; o.c = ((a >> (W - 1)) & 1) != 0; end
            OP_SHR1: begin raw = a >> 1;          o.c = (a & 1) != 0; end
            default: begin
                raw = (a * b) & mask;
                hi  = (a * b) >> W;
                o.c = hi != 0;
            end
        endcase
        o.res = raw[W-1:0];
        o.hi  = hi[W-1:0];
        o.z   = (raw == 0) && (hi == 0);
        return o;
    endfunction

    // Cycle-level expectation: what the outputs must show after each rising edge.
    out_t exp_out, pend_out;
    logic exp_done;
    logic m_busy;
    int   m_left;

    always @(posedge clock) begin
        exp_done <= 1'b0;
        if (reset) begin
            exp_out <= '0;
            m_busy  <= 1'b0;
            m_left  <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                exp_out  <= pend_out;
                exp_done <= 1'b1;
                m_busy   <= 1'b0;
            end
        end else if (bus.start) begin
            if (bus.opCode == OP_MUL) begin
                pend_out <= model(bus.opCode, bus.operand1, bus.operand2);
                m_busy   <= 1'b1;
                m_left   <= W;
            end else begin
                exp_out  <= model(bus.opCode, bus.operand1, bus.operand2);
                exp_done <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("cyc_result",   bus.result,       exp_out.res);
            check("cyc_high",     bus.resultHigh,   exp_out.hi);
            check("cyc_zero",     bus.zeroFlag,     exp_out.z);
            check("cyc_carry",    bus.carryFlag,    exp_out.c);
            check("cyc_overflow", bus.overflowFlag, exp_out.v);
            check("cyc_done",     bus.done,         exp_done);
            check("cyc_busy",     bus.busy,         m_busy);
        end
    end

    int done_edges;
    int busy_cnt;

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        busy_cnt = 0;
        @(negedge clock);
        bus.start = 1'b1; bus.opCode = op; bus.operand1 = a; bus.operand2 = b;
        @(negedge clock);
        bus.start = 1'b0;
        while (!bus.done && n < 40) begin
            if (bus.busy) busy_cnt++;
            @(negedge clock);
            n++;
        end
        check("done_seen", bus.done, 1'b1);
        done_edges = n;
    endtask

    int dones;
    logic [W-1:0] seen_res;

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.opCode = '0; bus.operand1 = '0; bus.operand2 = '0;
        repeat (2) @(negedge clock);
        check("rst_result", bus.result, 0);
        check("rst_high",   bus.resultHigh, 0);
        check("rst_busy",   bus.busy, 0);
        check("rst_done",   bus.done, 0);
        check("rst_flags",  {bus.zeroFlag, bus.carryFlag, bus.overflowFlag}, 0);
        cmp_en = 1'b1;
        reset  = 1'b0;

        do_op(OP_ADD, 8'd200, 8'd100);
        check("add_latency", done_edges, 0);
`ifdef ALU_SATURATE_EN
        check("add_res", bus.result, 8'hFF);
`else
        check("add_res", bus.result, 8'h2C);
`endif
        check("add_cvz", {bus.carryFlag, bus.overflowFlag, bus.zeroFlag}, 3'b100);

        do_op(OP_ADD, 8'd100, 8'd50);
        check("add_ovf_res", bus.result, 8'h96);
        check("add_ovf_cvz", {bus.carryFlag, bus.overflowFlag, bus.zeroFlag}, 3'b010);

        do_op(OP_SUB, 8'd3, 8'd5);
`ifdef ALU_SATURATE_EN
        check("sub_borrow_res", bus.result, 8'h00);
        check("sub_borrow_cvz", {bus.carryFlag, bus.overflowFlag, bus.zeroFlag}, 3'b101);
`else
        check("sub_borrow_res", bus.result, 8'hFE);
        check("sub_borrow_cvz", {bus.carryFlag, bus.overflowFlag, bus.zeroFlag}, 3'b100);
`endif

        do_op(OP_SUB, 8'd5, 8'd5);
        check("sub_zero_res", bus.result, 8'h00);
        check("sub_zero_cvz", {bus.carryFlag, bus.overflowFlag, bus.zeroFlag}, 3'b001);

        do_op(OP_MUL, 8'd200, 8'd200);
        check("mul_latency", done_edges, W);
        check("mul_busy_cycles", busy_cnt, W);
        check("mul_product", {bus.resultHigh, bus.result}, 16'h9C40);
        check("mul_carry", bus.carryFlag, 1'b1);

        do_op(OP_MUL, 8'd15, 8'd17);
        check("mul_small", {bus.resultHigh, bus.result}, 16'h00FF);
        check("mul_small_carry", bus.carryFlag, 1'b0);

        do_op(OP_SHL1, 8'h81, 8'h00);
        check("shl_res_c", {bus.result, bus.carryFlag}, {8'h02, 1'b1});
        do_op(OP_SHR1, 8'h01, 8'h00);
        check("shr_res_cz", {bus.result, bus.carryFlag, bus.zeroFlag}, {8'h00, 2'b11});
        do_op(OP_XOR, 8'hAA, 8'hAA);
        check("xor_res_cz", {bus.result, bus.carryFlag, bus.zeroFlag}, {8'h00, 2'b01});

        // Back-to-back single-cycle ops.
        @(negedge clock);
        bus.start = 1'b1; bus.opCode = OP_ADD; bus.operand1 = 8'd1; bus.operand2 = 8'd2;
        @(negedge clock);
        check("b2b_first", {bus.done, bus.result}, {1'b1, 8'd3});
        bus.opCode = OP_SUB; bus.operand1 = 8'd9; bus.operand2 = 8'd4;
        @(negedge clock);
        bus.start = 1'b0;
        check("b2b_second", {bus.done, bus.result}, {1'b1, 8'd5});

        // Start during MUL is dropped, not queued.
        @(negedge clock);
        bus.start = 1'b1; bus.opCode = OP_MUL; bus.operand1 = 8'd3; bus.operand2 = 8'd4;
        @(negedge clock);
        bus.start = 1'b0; bus.operand1 = 8'hFF; bus.operand2 = 8'hFF;
        repeat (2) @(negedge clock);
        bus.start = 1'b1; bus.opCode = OP_ADD; bus.operand1 = 8'd1; bus.operand2 = 8'd1;
        @(negedge clock);
        bus.start = 1'b0;
        dones = 0; seen_res = '0;
        repeat (W + 4) begin
            if (bus.done) begin dones++; seen_res = bus.result; end
            @(negedge clock);
        end
        check("ignored_start_dones", dones, 1);
        check("ignored_start_res", seen_res, 8'h0C);

        // Reset in the middle of a MUL.
        bus.start = 1'b1; bus.opCode = OP_MUL; bus.operand1 = 8'd200; bus.operand2 = 8'd200;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_outputs", {bus.result, bus.resultHigh, bus.busy, bus.done,
                                bus.zeroFlag, bus.carryFlag, bus.overflowFlag}, 0);
        dones = 0;
        repeat (W + 2) begin
            if (bus.done) dones++;
            @(negedge clock);
        end
        check("abort_no_done", dones, 0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            bus.start     = ($urandom_range(0, 2) != 0);
            bus.opCode    = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       bus.operand1 = '0;
                1:       bus.operand1 = '1;
                default: bus.operand1 = W'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       bus.operand2 = '0;
                1:       bus.operand2 = '1;
                default: bus.operand2 = W'($urandom);
            endcase
            @(negedge clock);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (W + 2) @(negedge clock);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, sequential successor of the 8-bit add/sub ALU used in the CPU datapath.
- Generalised to WIDTH bits with eight operations, including a multi-cycle unsigned shift-add multiplier.
- Uses a start/busy/done handshake and registered results and flags; the control unit issues one operation at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 4..32).
- CNT_W, $clog2(WIDTH)+1, width of the multiply step counter (derived; not overridden).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a clock edge only while busy=0.
- opCode  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL1, 6 SHR1 (logical), 7 MUL (unsigned).
- operand1  input  WIDTH  first operand; latched on an accepted start.
- operand2  input  WIDTH  second operand; latched on an accepted start.
- result  output  WIDTH  registered result (low half for MUL).
- resultHigh  output  WIDTH  high half of the MUL product; 0 for all other ops.
- busy  output  1  high while a MUL is in progress.
- done  output  1  one-cycle pulse: result and flags updated this cycle.
- zeroFlag  output  1  result is 0 (MUL: the full 2*WIDTH product is 0).
- carryFlag  output  1  carry, borrow or shifted-out bit (see Behaviour).
- overflowFlag  output  1  signed two's-complement overflow (ADD/SUB only).

Behaviour:
- Reset: state=IDLE; result, resultHigh, busy, done, zeroFlag, carryFlag and overflowFlag all 0. Reset overrides start and aborts any MUL in progress; the partial product is discarded and no done pulse is produced.
- FSM states: IDLE, MUL.
- IDLE, start=1, opCode!=7: compute on the same edge, register result and flags, done=1 for the next cycle, remain in IDLE. Latency 1. Back-to-back starts are accepted every cycle.
- IDLE, start=1, opCode=7: latch operands, clear the accumulator, counter=WIDTH, busy=1, go to MUL.
- MUL: one shift-add step per edge; the counter decrements. After step WIDTH: register {resultHigh,result}, update flags, done=1, busy=0, go to IDLE.
- MUL timing: start sampled at edge k, done visible after edge k+WIDTH, busy high for exactly WIDTH cycles.
- start while busy=1 is ignored, and is not queued. Operand changes during MUL have no effect.
- Arithmetic is computed at WIDTH+1 bits; result takes the low WIDTH bits and wraps modulo 2^WIDTH.
- carryFlag:
  - ADD: carry out.
  - SUB: borrow (operand1<operand2 unsigned).
  - SHL1: operand1 MSB.
  - SHR1: operand1 LSB.
  - MUL: resultHigh!=0.
  - AND/OR/XOR: 0.
- overflowFlag:
  - ADD: the operands have the same sign and the result sign differs.
  - SUB: the operands have different signs and the result sign differs from operand1.
  - All other ops: 0.
- Outputs and flags hold their values between done pulses. done is never high for two consecutive cycles for the same operation.

Optional Feature:
- Macro ALU_SATURATE_EN.
- Defined: ADD with carry out gives result of all ones; SUB with borrow gives result 0. carryFlag and overflowFlag still report the raw unsaturated condition. zeroFlag reflects the saturated result.
- Undefined: ADD/SUB wrap modulo 2^WIDTH. Other ops are unaffected in both cases.

Test Plan (WIDTH=8):
- ADD 200+100, start 1 cycle: result=0x2C, carry=1, overflow=0, zero=0, done one cycle after start. With ALU_SATURATE_EN: result=0xFF, carry=1.
- ADD 100+50: result=0x96, overflow=1, carry=0. Then SUB 3-5: result=0xFE, carry=1, overflow=0. Then SUB 5-5: result=0x00, zero=1, carry=0. With ALU_SATURATE_EN, SUB 3-5 gives result=0x00, zero=1.
- MUL 200*200: busy=1 for 8 cycles, done exactly 8 cycles after start, resultHigh=0x9C, result=0x40, carry=1. MUL 15*17 gives 0x00:0xFF, carry=0.
- During MUL 3*4, pulse start with ADD 1+1 at cycle 3: it is ignored, and the final result is 0x0C with a single done pulse. Reset asserted at cycle 5 of a second MUL: all outputs 0 next cycle, no done pulse.
- SHL1 0x81 gives 0x02, carry=1. SHR1 0x01 gives 0x00, carry=1, zero=1. XOR 0xAA^0xAA gives 0x00, zero=1, carry=0. Back-to-back starts on consecutive cycles each produce done.
